mem_port_sched: RTL and testbench
=================================

// Module: mem_port_sched
// PURPOSE
//  Shares one single-ported memory between instruction fetch (IF) and the MEM stage.
//  MEM stage requests are driven by the memread/memwrite/loadsig decode controls.
//  - Grants one requester at a time.
//  - Sequences the memory request/response handshake.
//  - Performs byte/half lane selection (zero-extended) for loads and byte enables for stores.
//  - Raises per-stage stall signals until the access completes.
// PARAMETERS
//  AW          32  address width (byte address)
//  MAX_STREAK  4   consecutive MEM grants allowed while IF waits before IF is forced (>=1)
// PORTS
//  i_clk          in   1   clock, all state on rising edge
//  i_rst_n        in   1   synchronous active-low reset
//  i_if_req       in   1   IF word read request, held until o_if_done
//  i_if_addr      in   AW  IF address, bits[1:0] ignored
//  o_if_done      out  1   1-cycle pulse, o_if_rdata valid
//  o_if_rdata     out  32  fetched word
//  o_if_stall     out  1   i_if_req & ~o_if_done
//  i_mem_read     in   1   load request (memread), held until o_mem_done
//  i_mem_write    in   1   store request (memwrite), held until o_mem_done
//  i_mem_size     in   2   00 word, 01 half, 10 byte, 11 treated as word
//  i_mem_addr     in   AW  data byte address
//  i_mem_wdata    in   32  store data, right-aligned
//  o_mem_done     out  1   1-cycle completion pulse
//  o_mem_rdata    out  32  load data, lane-selected, zero-extended
//  o_mem_stall    out  1   (i_mem_read|i_mem_write) & ~o_mem_done
//  o_ram_req      out  1   request to memory, held until i_ram_gnt
//  o_ram_we       out  1   1 write, 0 read
//  o_ram_addr     out  AW  word-aligned address ([1:0]=0)
//  o_ram_wdata    out  32  lane-replicated store data
//  o_ram_be       out  4   byte enables (reads: 4'b1111)
//  i_ram_gnt      in   1   memory accepts request this cycle
//  i_ram_rvalid   in   1   response: read data or write ack
//  i_ram_rdata    in   32  read data, valid with i_ram_rvalid
// BEHAVIOUR
//  - Reset (i_rst_n=0 at edge):
//    - State IDLE, streak counter 0.
//    - All outputs 0, except o_*_stall, which are combinational from the request inputs.
//  - FSM IDLE -> REQ -> WAIT -> IDLE; owner register (IF/MEM) is latched on leaving IDLE.
//  - IDLE arbitration (combinational on request inputs):
//    - MEM pending and (IF idle or streak<MAX_STREAK): grant MEM, streak += 1 (saturating).
//    - Otherwise, IF pending: grant IF, streak <= 0.
//    - Neither pending: stay in IDLE.
//  - i_mem_read & i_mem_write both set: treated as write.
//  - REQ:
//    - o_ram_req=1; address, we, be and wdata are registered and stable.
//    - On i_ram_gnt, go to WAIT next cycle.
//    - i_ram_gnt may be high in the same cycle req rises (zero-wait grant).
//  - WAIT:
//    - o_ram_req=0; on i_ram_rvalid, pulse the owner's done for exactly 1 cycle and return to IDLE.
//    - rdata is registered with done and held until the next done for that port.
//  - Minimum latency: request-to-done is 3 cycles (IDLE->REQ, gnt, rvalid), done registered.
//    - Back-to-back: the next arbitration happens in the cycle after done.
//  - i_ram_rvalid outside WAIT is ignored (e.g. late response after reset).
//  - Lane rules (little-endian, a=i_mem_addr[1:0]):
//    - Byte load: rdata={24'b0, word[8a+7:8a]}; be=4'b0001<<a; wdata={4{wdata[7:0]}}.
//    - Half load: a[1] selects the half, a[0] ignored; be=4'b0011<<(2*a[1]); wdata={2{wdata[15:0]}}.
//    - Word: a ignored; be=4'b1111.
//  - A requester deasserting before its done: transaction completes on memory anyway.
//    - done still pulses; the requester ignores it.
//  - Reset mid-transaction: the FSM aborts immediately and no done is issued.
// TESTING
//  - Reset: hold i_rst_n=0 with reqs high -> o_ram_req=0, o_*_done=0, state IDLE; release -> grant.
//  - IF only, addr 0x40, gnt same cycle, rvalid 1 cycle later, rdata 0xDEADBEEF
//    -> o_if_done at cycle 3, o_if_rdata=0xDEADBEEF, o_ram_addr=0x40.
//  - Simultaneous IF+MEM: MEM wins; MAX_STREAK=4 with MEM continuously requesting
//    -> IF granted on the 5th arbitration, then streak resets.
//  - lbu addr 0x103, ram word 0xA1B2C3D4 -> o_mem_rdata=0x000000A1;
//    lhu addr 0x102 -> 0x0000A1B2.
//  - sb addr 0x101 wdata 0x55 -> o_ram_be=4'b0010, o_ram_wdata=0x55555555, o_ram_we=1.
//  - gnt delayed 3 cycles, stray rvalid while in IDLE, reset in WAIT
//    -> req held stable, stray ignored, no done after reset.

Source files
------------

// File: rtl/mem_port_sched.sv
// Arbitrates one single-ported memory between instruction fetch and the MEM stage,
// sequencing the req/gnt/rvalid handshake and handling byte/half lanes.
module mem_port_sched #(
  parameter int unsigned AW         = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_done,
  output logic [31:0]   o_if_rdata,
  output logic          o_if_stall,
  input  logic          i_mem_read,
  input  logic          i_mem_write,
  input  logic [1:0]    i_mem_size,
  input  logic [AW-1:0] i_mem_addr,
  input  logic [31:0]   i_mem_wdata,
  output logic          o_mem_done,
  output logic [31:0]   o_mem_rdata,
  output logic          o_mem_stall,
  output logic          o_ram_req,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [31:0]   o_ram_wdata,
  output logic [3:0]    o_ram_be,
  input  logic          i_ram_gnt,
  input  logic          i_ram_rvalid,
  input  logic [31:0]   i_ram_rdata
);

  localparam int unsigned SW = (MAX_STREAK < 2) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic          owner_mem_q;
  logic [SW-1:0] streak_q;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;

  logic          mem_pend_c, grant_mem_c, grant_if_c;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c, load_c;

  logic          if_done_d, mem_done_d, ram_req_d, ram_we_d;
  logic [31:0]   if_rdata_d, mem_rdata_d, ram_wdata_d;
  logic [AW-1:0] ram_addr_d;
  logic [3:0]    ram_be_d;

  assign o_if_stall  = i_if_req & ~o_if_done;
  assign o_mem_stall = (i_mem_read | i_mem_write) & ~o_mem_done;

  // MEM has priority until it has won MAX_STREAK times in a row over a waiting IF
  assign mem_pend_c  = i_mem_read | i_mem_write;
  assign grant_mem_c = mem_pend_c & (~i_if_req | (streak_q < SW'(MAX_STREAK)));
  assign grant_if_c  = ~grant_mem_c & i_if_req;

  // Store lane placement; loads always read the full word
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = i_mem_wdata;
    case (i_mem_size)
      2'b10: begin
        wdata_c = {4{i_mem_wdata[7:0]}};
        if (i_mem_write) be_c = 4'b0001 << i_mem_addr[1:0];
      end
      2'b01: begin
        wdata_c = {2{i_mem_wdata[15:0]}};
        if (i_mem_write) be_c = i_mem_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load lane extraction, zero-extended
  always_comb begin
    load_c = i_ram_rdata;
    case (size_q)
      2'b10: begin
        case (lane_q)
          2'd0:    load_c = {24'b0, i_ram_rdata[7:0]};
          2'd1:    load_c = {24'b0, i_ram_rdata[15:8]};
          2'd2:    load_c = {24'b0, i_ram_rdata[23:16]};
          default: load_c = {24'b0, i_ram_rdata[31:24]};
        endcase
      end
      2'b01:   load_c = lane_q[1] ? {16'b0, i_ram_rdata[31:16]} : {16'b0, i_ram_rdata[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      owner_mem_q <= 1'b0;
      streak_q    <= '0;
      lane_q      <= 2'b00;
      size_q      <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && grant_mem_c) begin
        owner_mem_q <= 1'b1;
        lane_q      <= i_mem_addr[1:0];
        size_q      <= i_mem_size;
        if (streak_q < SW'(MAX_STREAK)) streak_q <= streak_q + SW'(1);
      end else if (state_q == S_IDLE && grant_if_c) begin
        owner_mem_q <= 1'b0;
        lane_q      <= 2'b00;
        size_q      <= 2'b00;
        streak_q    <= '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_mem_c || grant_if_c) state_d = S_REQ;
      S_REQ:   if (i_ram_gnt) state_d = S_WAIT;
      S_WAIT:  if (i_ram_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_rdata_d  = o_if_rdata;
    mem_rdata_d = o_mem_rdata;
    ram_req_d   = (state_d == S_REQ);
    ram_we_d    = o_ram_we;
    ram_addr_d  = o_ram_addr;
    ram_wdata_d = o_ram_wdata;
    ram_be_d    = o_ram_be;
    if (state_q == S_IDLE && grant_mem_c) begin
      ram_we_d    = i_mem_write;
      ram_addr_d  = i_mem_addr & WORD_MASK;
      ram_wdata_d = wdata_c;
      ram_be_d    = be_c;
    end else if (state_q == S_IDLE && grant_if_c) begin
      ram_we_d    = 1'b0;
      ram_addr_d  = i_if_addr & WORD_MASK;
      ram_wdata_d = 32'h0;
      ram_be_d    = 4'b1111;
    end
    if (state_q == S_WAIT && i_ram_rvalid) begin
      if (owner_mem_q) begin
        mem_done_d  = 1'b1;
        mem_rdata_d = load_c;
      end else begin
        if_done_d  = 1'b1;
        if_rdata_d = i_ram_rdata;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_if_done   <= 1'b0;
      o_if_rdata  <= 32'h0;
      o_mem_done  <= 1'b0;
      o_mem_rdata <= 32'h0;
      o_ram_req   <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= 32'h0;
      o_ram_be    <= 4'b0000;
    end else begin
      o_if_done   <= if_done_d;
      o_if_rdata  <= if_rdata_d;
      o_mem_done  <= mem_done_d;
      o_mem_rdata <= mem_rdata_d;
      o_ram_req   <= ram_req_d;
      o_ram_we    <= ram_we_d;
      o_ram_addr  <= ram_addr_d;
      o_ram_wdata <= ram_wdata_d;
      o_ram_be    <= ram_be_d;
    end
  end

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched: lane vectors table plus handshake corner sequences.
module tb_mem_port_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        mem_read, mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        ram_req, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_gnt, ram_rvalid;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_sched #(.AW(32), .MAX_STREAK(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_done(if_done), .o_if_rdata(if_rdata), .o_if_stall(if_stall),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_size(mem_size),
    .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .o_mem_done(mem_done), .o_mem_rdata(mem_rdata), .o_mem_stall(mem_stall),
    .o_ram_req(ram_req), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .o_ram_be(ram_be),
    .i_ram_gnt(ram_gnt), .i_ram_rvalid(ram_rvalid), .i_ram_rdata(ram_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ram_word;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req     = 1'b0;
    if_addr    = 32'h0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_size   = 2'b00;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    ram_gnt    = 1'b0;
    ram_rvalid = 1'b0;
    ram_rdata  = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic exp_mem [6];

    vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h103, 32'h0,        32'hA1B2C3D4, 32'h000000A1, 32'h0,        4'hF};
    vecs[1]  = '{1'b1, 1'b0, 2'b10, 32'h100, 32'h0,        32'hA1B2C3D4, 32'h000000D4, 32'h0,        4'hF};
    vecs[2]  = '{1'b1, 1'b0, 2'b10, 32'h101, 32'h0,        32'hA1B2C3D4, 32'h000000C3, 32'h0,        4'hF};
    vecs[3]  = '{1'b1, 1'b0, 2'b01, 32'h102, 32'h0,        32'hA1B2C3D4, 32'h0000A1B2, 32'h0,        4'hF};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 32'h101, 32'h0,        32'hA1B2C3D4, 32'h0000C3D4, 32'h0,        4'hF};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 32'h104, 32'h0,        32'h12345678, 32'h12345678, 32'h0,        4'hF};
    vecs[6]  = '{1'b1, 1'b0, 2'b11, 32'h10B, 32'h0,        32'h89ABCDEF, 32'h89ABCDEF, 32'h0,        4'hF};
    vecs[7]  = '{1'b0, 1'b1, 2'b10, 32'h101, 32'h55,       32'h0,        32'h0,        32'h55555555, 4'b0010};
    vecs[8]  = '{1'b0, 1'b1, 2'b01, 32'h102, 32'h0000BEEF, 32'h0,        32'h0,        32'hBEEFBEEF, 4'b1100};
    vecs[9]  = '{1'b0, 1'b1, 2'b00, 32'h108, 32'hCAFEF00D, 32'h0,        32'h0,        32'hCAFEF00D, 4'b1111};
    vecs[10] = '{1'b0, 1'b1, 2'b10, 32'h103, 32'h123456AB, 32'h0,        32'h0,        32'hABABABAB, 4'b1000};
    vecs[11] = '{1'b1, 1'b1, 2'b10, 32'h100, 32'h0000007F, 32'h0,        32'h0,        32'h7F7F7F7F, 4'b0001};
    vecs[12] = '{1'b0, 1'b1, 2'b01, 32'h101, 32'hAAAA5678, 32'h0,        32'h0,        32'h56785678, 4'b0011};
    exp_mem = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset held with both requests pending
    clear_inputs();
    rst_n    = 1'b0;
    if_req   = 1'b1;
    if_addr  = 32'h40;
    mem_read = 1'b1;
    mem_addr = 32'h100;
    step(); step(); step();
    chk("rst_ram_req", 32'(ram_req), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_mem_done", 32'(mem_done), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd1);
    chk("rst_if_stall", 32'(if_stall), 32'd1);
    rst_n = 1'b1;
    step();
    chk("rel_ram_req", 32'(ram_req), 32'd1);
    chk("rel_mem_wins_addr", ram_addr, 32'h100);
    clear_inputs();
    rst_n = 1'b0;
    step();
    chk("abort_req_ram_req", 32'(ram_req), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_ram_req", 32'(ram_req), 32'd0);

    // IF fetch, zero-wait grant
    if_req  = 1'b1;
    if_addr = 32'h40;
    step();
    chk("if_ram_req", 32'(ram_req), 32'd1);
    chk("if_ram_addr", ram_addr, 32'h40);
    chk("if_ram_we", 32'(ram_we), 32'd0);
    chk("if_ram_be", 32'(ram_be), 32'hF);
    chk("if_stall_busy", 32'(if_stall), 32'd1);
    ram_gnt = 1'b1;
    step();
    ram_gnt    = 1'b0;
    ram_rvalid = 1'b1;
    ram_rdata  = 32'hDEADBEEF;
    chk("if_wait_ram_req", 32'(ram_req), 32'd0);
    chk("if_wait_done", 32'(if_done), 32'd0);
    step();
    chk("if_done_c3", 32'(if_done), 32'd1);
    chk("if_rdata", if_rdata, 32'hDEADBEEF);
    chk("if_stall_done", 32'(if_stall), 32'd0);
    chk("if_mem_done_quiet", 32'(mem_done), 32'd0);
    if_req     = 1'b0;
    ram_rvalid = 1'b0;
    step();
    chk("if_done_pulse", 32'(if_done), 32'd0);
    chk("if_rdata_held", if_rdata, 32'hDEADBEEF);

    // Lane vectors
    for (int i = 0; i < 13; i++) begin
      mem_read  = vecs[i].rd;
      mem_write = vecs[i].wr;
      mem_size  = vecs[i].size;
      mem_addr  = vecs[i].addr;
      mem_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'd1);
      step();
      chk($sformatf("v%0d_req", i), 32'(ram_req), 32'd1);
      chk($sformatf("v%0d_addr", i), ram_addr, vecs[i].addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(vecs[i].wr));
      chk($sformatf("v%0d_be", i), 32'(ram_be), 32'(vecs[i].exp_be));
      if (vecs[i].wr) chk($sformatf("v%0d_wdata", i), ram_wdata, vecs[i].exp_wdata);
      ram_gnt = 1'b1;
      step();
      ram_gnt    = 1'b0;
      ram_rvalid = 1'b1;
      ram_rdata  = vecs[i].ram_word;
      step();
      chk($sformatf("v%0d_done", i), 32'(mem_done), 32'd1);
      chk($sformatf("v%0d_if_quiet", i), 32'(if_done), 32'd0);
      if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ram_rvalid = 1'b0;
      step();
      chk($sformatf("v%0d_done_pulse", i), 32'(mem_done), 32'd0);
    end

    // Stray rvalid while idle
    ram_rvalid = 1'b1;
    ram_rdata  = 32'hBAD0BAD0;
    step();
    chk("stray_ram_req", 32'(ram_req), 32'd0);
    ram_rvalid = 1'b0;
    step();
    chk("stray_if_done", 32'(if_done), 32'd0);
    chk("stray_mem_done", 32'(mem_done), 32'd0);
    chk("stray_if_rdata", if_rdata, 32'hDEADBEEF);

    // Grant delayed by 3 cycles: request must stay stable
    mem_write = 1'b1;
    mem_size  = 2'b00;
    mem_addr  = 32'h20;
    mem_wdata = 32'h11223344;
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dly%0d_req", k), 32'(ram_req), 32'd1);
      chk($sformatf("dly%0d_addr", k), ram_addr, 32'h20);
      chk($sformatf("dly%0d_wdata", k), ram_wdata, 32'h11223344);
      chk($sformatf("dly%0d_be", k), 32'(ram_be), 32'hF);
      step();
    end
    chk("dly_req_at_gnt", 32'(ram_req), 32'd1);
    ram_gnt = 1'b1;
    step();
    ram_gnt = 1'b0;
    chk("dly_wait_req", 32'(ram_req), 32'd0);
    ram_rvalid = 1'b1;
    step();
    chk("dly_done", 32'(mem_done), 32'd1);
    mem_write  = 1'b0;
    ram_rvalid = 1'b0;
    step();

    // Reset in WAIT with response arriving: no done, and late response ignored
    if_req  = 1'b1;
    if_addr = 32'h80;
    step();
    ram_gnt = 1'b1;
    step();
    ram_gnt    = 1'b0;
    ram_rvalid = 1'b1;
    ram_rdata  = 32'h0BADF00D;
    rst_n      = 1'b0;
    step();
    chk("rstw_if_done", 32'(if_done), 32'd0);
    chk("rstw_ram_req", 32'(ram_req), 32'd0);
    chk("rstw_if_rdata", if_rdata, 32'h0);
    rst_n  = 1'b1;
    if_req = 1'b0;
    step();
    chk("late_if_done", 32'(if_done), 32'd0);
    chk("late_mem_done", 32'(mem_done), 32'd0);
    ram_rvalid = 1'b0;
    step();
    chk("late_ram_req", 32'(ram_req), 32'd0);

    // Streak: MEM and IF both pending, streak counter freshly reset
    if_req   = 1'b1;
    if_addr  = 32'h200;
    mem_read = 1'b1;
    mem_size = 2'b00;
    mem_addr = 32'h300;
    for (int t = 0; t < 6; t++) begin
      n = 0;
      step();
      while (!ram_req && n < 4) begin
        step();
        n++;
      end
      chk($sformatf("stk%0d_req", t), 32'(ram_req), 32'd1);
      chk($sformatf("stk%0d_owner_addr", t), ram_addr, exp_mem[t] ? 32'h300 : 32'h200);
      ram_gnt = 1'b1;
      step();
      ram_gnt    = 1'b0;
      ram_rvalid = 1'b1;
      ram_rdata  = 32'(t) + 32'h1000;
      step();
      ram_rvalid = 1'b0;
      chk($sformatf("stk%0d_mem_done", t), 32'(mem_done), 32'(exp_mem[t]));
      chk($sformatf("stk%0d_if_done", t), 32'(if_done), 32'(!exp_mem[t]));
      if (exp_mem[t]) chk($sformatf("stk%0d_mem_rdata", t), mem_rdata, 32'(t) + 32'h1000);
      else            if_req = 1'b0;
    end
    mem_read = 1'b0;
    step();
    step();
    chk("end_ram_req", 32'(ram_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
